// File: rtl/axil_func_regfile.sv
// axil_func_regfile: AXI-lite slave holding one REG_COUNT-deep register bank per SR-IOV function, bank picked by awuser/aruser, reg 0 a read-only ID
module axil_func_regfile #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int STRB_WIDTH = DATA_WIDTH/8,
   parameter int FUNCTION_ID_WIDTH = 8,
   parameter int FUNC_COUNT = 4,
   parameter int REG_COUNT = 8,
   parameter logic [31:0] ID_VALUE = 32'h5A5A0000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ADDR_WIDTH-1:0]        s_axil_awaddr,
   input  logic [FUNCTION_ID_WIDTH-1:0] s_axil_awuser,
   input  logic [2:0]                   s_axil_awprot,
   input  logic                         s_axil_awvalid,
   output logic                         s_axil_awready,
   input  logic [DATA_WIDTH-1:0]        s_axil_wdata,
   input  logic [STRB_WIDTH-1:0]        s_axil_wstrb,
   input  logic                         s_axil_wvalid,
   output logic                         s_axil_wready,
   output logic [1:0]                   s_axil_bresp,
   output logic                         s_axil_bvalid,
   input  logic                         s_axil_bready,
   input  logic [ADDR_WIDTH-1:0]        s_axil_araddr,
   input  logic [FUNCTION_ID_WIDTH-1:0] s_axil_aruser,
   input  logic [2:0]                   s_axil_arprot,
   input  logic                         s_axil_arvalid,
   output logic                         s_axil_arready,
   output logic [DATA_WIDTH-1:0]        s_axil_rdata,
   output logic [1:0]                   s_axil_rresp,
   output logic                         s_axil_rvalid,
   input  logic                         s_axil_rready
);
   localparam int ADDR_LSB = $clog2(STRB_WIDTH);
   localparam int IDX_W = $clog2(REG_COUNT);
   localparam int FI_W = FUNC_COUNT > 1 ? $clog2(FUNC_COUNT) : 1;
   localparam int UW = FUNCTION_ID_WIDTH + 1;
   localparam logic [31:0] ID_MASK = 32'((64'd1 << FUNCTION_ID_WIDTH) - 64'd1);
   typedef enum logic {IDLE, RESP} state_t;
   state_t ws, ws_n, rs, rs_n;
   logic [DATA_WIDTH-1:0] mem [FUNC_COUNT][REG_COUNT];
   logic [IDX_W-1:0] wi, ri;
   logic [FI_W-1:0] wf, rf;
   logic w_in, w_ok, r_in, aw_hs, ar_hs;
   logic [DATA_WIDTH-1:0] id_word, rd_val;
   logic unused;
   assign unused = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr};
   always_comb begin
      wi = s_axil_awaddr[ADDR_LSB +: IDX_W];
      ri = s_axil_araddr[ADDR_LSB +: IDX_W];
      wf = s_axil_awuser[FI_W-1:0];
      rf = s_axil_aruser[FI_W-1:0];
      w_in = ((s_axil_awaddr >> ADDR_LSB) < ADDR_WIDTH'(REG_COUNT)) && ({1'b0, s_axil_awuser} < UW'(FUNC_COUNT));
      r_in = ((s_axil_araddr >> ADDR_LSB) < ADDR_WIDTH'(REG_COUNT)) && ({1'b0, s_axil_aruser} < UW'(FUNC_COUNT));
      w_ok = w_in && (wi != '0);
      id_word = DATA_WIDTH'((ID_VALUE & ~ID_MASK) | 32'(s_axil_aruser));
      rd_val = !r_in ? '0 : (ri == '0) ? id_word : mem[rf][ri];
      aw_hs = (ws == IDLE) && s_axil_awvalid && s_axil_wvalid;
      ar_hs = (rs == IDLE) && s_axil_arvalid;
      s_axil_awready = aw_hs;
      s_axil_wready = aw_hs;
      s_axil_arready = ar_hs;
      s_axil_bvalid = ws == RESP;
      s_axil_rvalid = rs == RESP;
      ws_n = (ws == IDLE) ? (aw_hs ? RESP : IDLE) : (s_axil_bready ? IDLE : RESP);
      rs_n = (rs == IDLE) ? (ar_hs ? RESP : IDLE) : (s_axil_rready ? IDLE : RESP);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ws <= IDLE;
         rs <= IDLE;
         s_axil_bresp <= 2'b00;
         s_axil_rresp <= 2'b00;
         s_axil_rdata <= '0;
         for (int f = 0; f < FUNC_COUNT; f++)
            for (int r = 0; r < REG_COUNT; r++)
               mem[f][r] <= '0;
      end else begin
         ws <= ws_n;
         rs <= rs_n;
         if (aw_hs)
            s_axil_bresp <= w_ok ? 2'b00 : 2'b10;
         if (ar_hs) begin
            s_axil_rdata <= rd_val;
            s_axil_rresp <= r_in ? 2'b00 : 2'b10;
         end
         if (aw_hs && w_ok)
            for (int b = 0; b < STRB_WIDTH; b++)
               if (s_axil_wstrb[b])
                  mem[wf][wi][8*b +: 8] <= s_axil_wdata[8*b +: 8];
      end
   end
endmodule

// File: tb/tb_axil_func_regfile.sv
// tb_axil_func_regfile: table, hand-sequence and random checks of axil_func_regfile against a bank-array model
module tb_axil_func_regfile;
   logic clk = 0;
   logic rst = 1;
   logic [15:0] s_axil_awaddr = 0, s_axil_araddr = 0;
   logic [7:0] s_axil_awuser = 0, s_axil_aruser = 0;
   logic [2:0] s_axil_awprot = 0, s_axil_arprot = 0;
   logic s_axil_awvalid = 0, s_axil_wvalid = 0, s_axil_bready = 0, s_axil_arvalid = 0, s_axil_rready = 0;
   logic [31:0] s_axil_wdata = 0;
   logic [3:0] s_axil_wstrb = 0;
   logic s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid;
   logic [1:0] s_axil_bresp, s_axil_rresp;
   logic [31:0] s_axil_rdata;
   int checks = 0;
   int errors = 0;
   logic [31:0] model [4][8];

   axil_func_regfile dut (
      .clk(clk), .rst(rst),
      .s_axil_awaddr(s_axil_awaddr), .s_axil_awuser(s_axil_awuser), .s_axil_awprot(s_axil_awprot),
      .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
      .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
      .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
      .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_aruser(s_axil_aruser),
      .s_axil_arprot(s_axil_arprot), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
      .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
      .s_axil_rready(s_axil_rready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tmo(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timeout, got 0 expected 1", name);
   endtask

   function automatic void clear_model();
      for (int f = 0; f < 4; f++)
         for (int r = 0; r < 8; r++)
            model[f][r] = 0;
   endfunction

   function automatic logic [1:0] mwrite(input int f, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
      int i = 32'(a) >> 2;
      if (f >= 4 || i >= 8 || i == 0) return 2'b10;
      for (int b = 0; b < 4; b++)
         if (s[b]) model[f][i][8*b +: 8] = d[8*b +: 8];
      return 2'b00;
   endfunction

   function automatic logic [33:0] mread(input int f, input logic [15:0] a);
      int i = 32'(a) >> 2;
      if (f >= 4 || i >= 8) return {2'b10, 32'h0};
      if (i == 0) return {2'b00, 32'h5A5A0000 | 32'(f)};
      return {2'b00, model[f][i]};
   endfunction

   task automatic do_write(input logic [7:0] f, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
      int n = 0;
      @(negedge clk);
      s_axil_awuser = f; s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s;
      s_axil_awvalid = 1; s_axil_wvalid = 1;
      #1;
      while (!s_axil_awready) begin
         if (++n > 20) begin tmo("awready"); break; end
         @(negedge clk); #1;
      end
      @(negedge clk);
      s_axil_awvalid = 0; s_axil_wvalid = 0;
      #1;
      n = 0;
      while (!s_axil_bvalid) begin
         if (++n > 20) begin tmo("bvalid"); break; end
         @(negedge clk); #1;
      end
      resp = s_axil_bresp;
      s_axil_bready = 1;
      @(negedge clk);
      s_axil_bready = 0;
   endtask

   task automatic do_read(input logic [7:0] f, input logic [15:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n = 0;
      @(negedge clk);
      s_axil_aruser = f; s_axil_araddr = a; s_axil_arvalid = 1;
      #1;
      while (!s_axil_arready) begin
         if (++n > 20) begin tmo("arready"); break; end
         @(negedge clk); #1;
      end
      @(negedge clk);
      s_axil_arvalid = 0;
      #1;
      n = 0;
      while (!s_axil_rvalid) begin
         if (++n > 20) begin tmo("rvalid"); break; end
         @(negedge clk); #1;
      end
      d = s_axil_rdata;
      resp = s_axil_rresp;
      s_axil_rready = 1;
      @(negedge clk);
      s_axil_rready = 0;
   endtask

   typedef struct {
      bit wr;
      int f;
      logic [15:0] a;
      logic [31:0] d;
      logic [3:0] s;
      logic [1:0] er;
      logic [31:0] ed;
   } vec_t;

   initial begin
      vec_t tbl[$];
      logic [1:0] resp;
      logic [31:0] rd;
      logic [33:0] exp;
      clear_model();
      tbl.push_back('{1, 2, 16'h0004, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0});
      tbl.push_back('{0, 2, 16'h0004, 32'h0, 4'h0, 2'b00, 32'hDEADBEEF});
      tbl.push_back('{0, 1, 16'h0004, 32'h0, 4'h0, 2'b00, 32'h00000000});
      tbl.push_back('{1, 0, 16'h000C, 32'h11223344, 4'hF, 2'b00, 32'h0});
      tbl.push_back('{1, 0, 16'h000C, 32'hAABBCCDD, 4'h5, 2'b00, 32'h0});
      tbl.push_back('{0, 0, 16'h000C, 32'h0, 4'h0, 2'b00, 32'h11BB33DD});
      tbl.push_back('{1, 4, 16'h0004, 32'h12345678, 4'hF, 2'b10, 32'h0});
      tbl.push_back('{0, 0, 16'h0004, 32'h0, 4'h0, 2'b00, 32'h00000000});
      tbl.push_back('{0, 2, 16'h0004, 32'h0, 4'h0, 2'b00, 32'hDEADBEEF});
      tbl.push_back('{0, 4, 16'h0004, 32'h0, 4'h0, 2'b10, 32'h00000000});
      tbl.push_back('{0, 2, 16'h0020, 32'h0, 4'h0, 2'b10, 32'h00000000});
      tbl.push_back('{1, 1, 16'h0000, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0});
      tbl.push_back('{1, 2, 16'h0020, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0});
      tbl.push_back('{0, 1, 16'h0000, 32'h0, 4'h0, 2'b00, 32'h5A5A0001});
      tbl.push_back('{0, 3, 16'h0000, 32'h0, 4'h0, 2'b00, 32'h5A5A0003});
      tbl.push_back('{0, 2, 16'h0007, 32'h0, 4'h0, 2'b00, 32'hDEADBEEF});
      tbl.push_back('{1, 3, 16'h001C, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h0});
      tbl.push_back('{0, 3, 16'h001C, 32'h0, 4'h0, 2'b00, 32'h00000000});
      tbl.push_back('{1, 3, 16'h001E, 32'hFFFFFFFF, 4'hC, 2'b00, 32'h0});
      tbl.push_back('{0, 3, 16'h001C, 32'h0, 4'h0, 2'b00, 32'hFFFF0000});

      repeat (3) @(negedge clk);
      #1;
      chk("reset_bvalid", 64'(s_axil_bvalid), 0);
      chk("reset_rvalid", 64'(s_axil_rvalid), 0);
      chk("reset_rdata", 64'(s_axil_rdata), 0);
      chk("reset_resp", 64'({s_axil_bresp, s_axil_rresp}), 0);
      rst = 0;
      #1;
      chk("idle_ready", 64'({s_axil_awready, s_axil_wready, s_axil_arready}), 0);

      foreach (tbl[k]) begin
         if (tbl[k].wr) begin
            do_write(8'(tbl[k].f), tbl[k].a, tbl[k].d, tbl[k].s, resp);
            void'(mwrite(tbl[k].f, tbl[k].a, tbl[k].d, tbl[k].s));
            chk($sformatf("tbl%0d_bresp", k), 64'(resp), 64'(tbl[k].er));
         end else begin
            do_read(8'(tbl[k].f), tbl[k].a, rd, resp);
            chk($sformatf("tbl%0d_rresp", k), 64'(resp), 64'(tbl[k].er));
            chk($sformatf("tbl%0d_rdata", k), 64'(rd), 64'(tbl[k].ed));
         end
      end

      // same-cycle read and write of one register: read sees the old value
      exp = mread(2, 16'h4);
      @(negedge clk);
      s_axil_awuser = 2; s_axil_awaddr = 16'h4; s_axil_wdata = 32'h01020304; s_axil_wstrb = 4'hF;
      s_axil_aruser = 2; s_axil_araddr = 16'h4;
      s_axil_awvalid = 1; s_axil_wvalid = 1; s_axil_arvalid = 1;
      #1;
      chk("simul_readies", 64'({s_axil_awready, s_axil_wready, s_axil_arready}), 64'h7);
      @(negedge clk);
      s_axil_awvalid = 0; s_axil_wvalid = 0; s_axil_arvalid = 0;
      #1;
      chk("simul_valids", 64'({s_axil_bvalid, s_axil_rvalid}), 64'h3);
      chk("simul_rdata_old", 64'(s_axil_rdata), 64'(exp[31:0]));
      chk("simul_bresp", 64'(s_axil_bresp), 0);
      s_axil_bready = 1; s_axil_rready = 1;
      @(negedge clk);
      s_axil_bready = 0; s_axil_rready = 0;
      void'(mwrite(2, 16'h4, 32'h01020304, 4'hF));
      do_read(2, 16'h4, rd, resp);
      chk("simul_rdata_new", 64'(rd), 64'h01020304);

      // B backpressure with a second write waiting
      @(negedge clk);
      s_axil_awuser = 0; s_axil_awaddr = 16'h0; s_axil_wdata = 32'h77777777; s_axil_wstrb = 4'hF;
      s_axil_awvalid = 1; s_axil_wvalid = 1;
      #1;
      chk("bp_w_accept", 64'(s_axil_awready), 1);
      @(negedge clk);
      s_axil_awuser = 2; s_axil_awaddr = 16'h14; s_axil_wdata = 32'hCAFE0055;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_bvalid", 64'(s_axil_bvalid), 1);
         chk("bp_bresp", 64'(s_axil_bresp), 64'h2);
         chk("bp_no_ready", 64'({s_axil_awready, s_axil_wready}), 0);
         @(negedge clk);
      end
      s_axil_bready = 1;
      @(negedge clk);
      s_axil_bready = 0;
      #1;
      chk("bp_w_next_ready", 64'({s_axil_awready, s_axil_wready, s_axil_bvalid}), 64'h6);
      @(negedge clk);
      s_axil_awvalid = 0; s_axil_wvalid = 0;
      #1;
      chk("bp_w2_resp", 64'({s_axil_bvalid, s_axil_bresp}), 64'h4);
      s_axil_bready = 1;
      @(negedge clk);
      s_axil_bready = 0;
      void'(mwrite(0, 16'h0, 32'h77777777, 4'hF));
      void'(mwrite(2, 16'h14, 32'hCAFE0055, 4'hF));

      // R backpressure with a second read waiting
      exp = mread(2, 16'h14);
      @(negedge clk);
      s_axil_aruser = 2; s_axil_araddr = 16'h14; s_axil_arvalid = 1;
      #1;
      chk("bp_r_accept", 64'(s_axil_arready), 1);
      @(negedge clk);
      s_axil_aruser = 3; s_axil_araddr = 16'h0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_rvalid", 64'(s_axil_rvalid), 1);
         chk("bp_rdata", 64'({s_axil_rresp, s_axil_rdata}), 64'(exp));
         chk("bp_no_arready", 64'(s_axil_arready), 0);
         @(negedge clk);
      end
      s_axil_rready = 1;
      @(negedge clk);
      s_axil_rready = 0;
      #1;
      chk("bp_r_next_ready", 64'({s_axil_arready, s_axil_rvalid}), 64'h2);
      @(negedge clk);
      s_axil_arvalid = 0;
      #1;
      chk("bp_r2_data", 64'({s_axil_rvalid, s_axil_rdata}), {31'h0, 1'b1, 32'h5A5A0003});
      s_axil_rready = 1;
      @(negedge clk);
      s_axil_rready = 0;

      // AW arrives three cycles before W
      @(negedge clk);
      s_axil_awuser = 1; s_axil_awaddr = 16'h8; s_axil_wdata = 32'h0BADF00D; s_axil_wstrb = 4'hF;
      s_axil_awvalid = 1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("skew_no_ready", 64'({s_axil_awready, s_axil_wready}), 0);
         @(negedge clk);
      end
      s_axil_wvalid = 1;
      #1;
      chk("skew_both_ready", 64'({s_axil_awready, s_axil_wready, s_axil_bvalid}), 64'h6);
      @(negedge clk);
      s_axil_awvalid = 0; s_axil_wvalid = 0;
      #1;
      chk("skew_bvalid", 64'({s_axil_bvalid, s_axil_bresp}), 64'h4);
      s_axil_bready = 1;
      @(negedge clk);
      s_axil_bready = 0;
      void'(mwrite(1, 16'h8, 32'h0BADF00D, 4'hF));

      // random traffic against the model
      for (int k = 0; k < 120; k++) begin
         int f = $urandom_range(0, 5);
         int idx = $urandom_range(0, 9);
         logic [15:0] a = 16'(idx * 4 + $urandom_range(0, 3));
         logic [31:0] d = $urandom;
         logic [3:0] s = 4'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            do_write(8'(f), a, d, s, resp);
            chk("rnd_bresp", 64'(resp), 64'(mwrite(f, a, d, s)));
         end else begin
            do_read(8'(f), a, rd, resp);
            chk("rnd_read", 64'({resp, rd}), 64'(mread(f, a)));
         end
      end

      // async reset while R is pending
      @(negedge clk);
      s_axil_aruser = 1; s_axil_araddr = 16'h8; s_axil_arvalid = 1;
      @(negedge clk);
      s_axil_arvalid = 0;
      #1;
      chk("ar_pre_rvalid", 64'({s_axil_rvalid, s_axil_rdata}), 64'(mread(1, 16'h8)) | 64'h100000000);
      #1;
      rst = 1;
      #1;
      chk("ar_rvalid_drop", 64'(s_axil_rvalid), 0);
      chk("ar_rdata_clear", 64'(s_axil_rdata), 0);
      repeat (2) @(negedge clk);
      rst = 0;
      clear_model();
      do_read(1, 16'h8, rd, resp);
      chk("ar_after_reset", 64'({resp, rd}), 64'(mread(1, 16'h8)));
      do_read(2, 16'h14, rd, resp);
      chk("ar_after_reset2", 64'({resp, rd}), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
